// File: rtl/cracker_pkg.sv
// Shared defaults and state encoding for the cracker front end.
// The candidate sequencer and its index odometer both import this package.
package cracker_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CHAR_W_DEF  = 7;
    localparam int IDX_W_DEF   = 6;
    localparam int LEN_W_DEF   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_OFFER,
        ST_STEP,
        ST_DONE
    } cand_state_t;

endpackage

// File: rtl/index_odometer.sv
// Mixed-radix counter of charset indices, position 0 least significant.
// Only the lowest cur_len digits count; higher digits stay at zero.
module index_odometer
    import cracker_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic [IDX_W-1:0] radix_i,
    input  logic [LEN_W-1:0] cur_len_i,
    input  logic [LEN_W-1:0] rd_sel_i,
    output logic             carry_out_o,
    output logic [IDX_W-1:0] rd_idx_o
);

    logic [IDX_W-1:0] idx_q [MAX_LEN];
    logic [MAX_LEN:0] carry;

    assign carry[0] = step_i;

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_digit
            logic [IDX_W-1:0] idx_d;

            // A digit sitting at radix-1 wraps to zero when a carry reaches it.
            assign carry[gi+1] = carry[gi] && (idx_q[gi] == radix_i - IDX_W'(1));

            always_comb begin
                idx_d = idx_q[gi];
                if (clear_i) begin
                    idx_d = '0;
                end else if (carry[gi] && (LEN_W'(gi) < cur_len_i)) begin
                    idx_d = carry[gi+1] ? '0 : idx_q[gi] + IDX_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    idx_q[gi] <= '0;
                end else begin
                    idx_q[gi] <= idx_d;
                end
            end
        end
    endgenerate

    always_comb begin
        carry_out_o = 1'b0;
        rd_idx_o    = '0;
        for (int p = 0; p <= MAX_LEN; p++) begin
            if (cur_len_i == LEN_W'(p)) carry_out_o = carry[p];
        end
        for (int p = 0; p < MAX_LEN; p++) begin
            if (rd_sel_i == LEN_W'(p)) rd_idx_o = idx_q[p];
        end
    end

endmodule

// File: rtl/candidate_sequencer.sv
// Brute-force candidate generator: walks all strings over the loaded charset,
// shortest first, fetching one character per cycle and offering each candidate.
module candidate_sequencer
    import cracker_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CHAR_W  = CHAR_W_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LEN_W-1:0]          min_len,
    input  logic [LEN_W-1:0]          max_len,
    input  logic [IDX_W-1:0]          cs_len,
    output logic [IDX_W-1:0]          cs_ord,
    input  logic [CHAR_W-1:0]         cs_char,
    output logic                      cand_valid,
    input  logic                      cand_ready,
    output logic [MAX_LEN*CHAR_W-1:0] cand_data,
    output logic [LEN_W-1:0]          cand_len,
    output logic                      busy,
    output logic                      done
);

    cand_state_t               state_q, state_d;
    logic [LEN_W-1:0]          cur_len_q, cur_len_d;
    logic [LEN_W-1:0]          pos_q, pos_d;
    logic [LEN_W-1:0]          max_len_q, max_len_d;
    logic [IDX_W-1:0]          len_q, len_d;
    logic [MAX_LEN*CHAR_W-1:0] data_q, data_d;

    logic             odo_clear;
    logic             odo_step;
    logic             odo_carry;
    logic [IDX_W-1:0] odo_idx;
    logic             cfg_ok;

    index_odometer #(
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W),
        .LEN_W   (LEN_W)
    ) u_odometer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (odo_clear),
        .step_i      (odo_step),
        .radix_i     (len_q),
        .cur_len_i   (cur_len_q),
        .rd_sel_i    (pos_q),
        .carry_out_o (odo_carry),
        .rd_idx_o    (odo_idx)
    );

    assign cfg_ok = (cs_len != '0) && (min_len != '0) && (min_len <= max_len)
                 && (max_len <= LEN_W'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cur_len_q <= '0;
            pos_q     <= '0;
            max_len_q <= '0;
            len_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cur_len_q <= cur_len_d;
            pos_q     <= pos_d;
            max_len_q <= max_len_d;
            len_q     <= len_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_len_d = cur_len_q;
        pos_d     = pos_q;
        max_len_d = max_len_q;
        len_d     = len_q;
        data_d    = data_q;
        odo_clear = 1'b0;
        odo_step  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d     = cs_len;
                    max_len_d = max_len;
                    if (cfg_ok) begin
                        odo_clear = 1'b1;
                        cur_len_d = min_len;
                        pos_d     = '0;
                        data_d    = '0;
                        state_d   = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                for (int p = 0; p < MAX_LEN; p++) begin
                    if (pos_q == LEN_W'(p)) data_d[p*CHAR_W +: CHAR_W] = cs_char;
                end
                if (pos_q == cur_len_q - LEN_W'(1)) begin
                    state_d = ST_OFFER;
                end else begin
                    pos_d = pos_q + LEN_W'(1);
                end
            end
            ST_OFFER: begin
                if (cand_ready) state_d = ST_STEP;
            end
            ST_STEP: begin
                odo_step = 1'b1;
                pos_d    = '0;
                state_d  = ST_FETCH;
                // Carry out of the top digit means this length is exhausted.
                if (odo_carry) begin
                    if (cur_len_q == max_len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_len_d = cur_len_q + LEN_W'(1);
                        odo_clear = 1'b1;
                        data_d    = '0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cs_ord     = (state_q == ST_FETCH) ? odo_idx : '0;
    assign cand_valid = (state_q == ST_OFFER);
    assign cand_len   = (state_q == ST_OFFER) ? cur_len_q : '0;
    assign cand_data  = data_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_candidate_sequencer.sv
// Directed bench for candidate_sequencer: full walks with an arithmetic
// reference model, invalid configurations, mid-run resets and ignored starts.
module tb_candidate_sequencer;

    localparam int MAX_LEN = 8;
    localparam int CHAR_W  = 7;
    localparam int IDX_W   = 6;
    localparam int LEN_W   = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      start;
    logic [LEN_W-1:0]          min_len;
    logic [LEN_W-1:0]          max_len;
    logic [IDX_W-1:0]          cs_len;
    logic [IDX_W-1:0]          cs_ord;
    logic [CHAR_W-1:0]         cs_char;
    logic                      cand_valid;
    logic                      cand_ready;
    logic [MAX_LEN*CHAR_W-1:0] cand_data;
    logic [LEN_W-1:0]          cand_len;
    logic                      busy;
    logic                      done;

    logic [CHAR_W-1:0] cs_mem [64];
    int total = 0;
    int bad   = 0;

    candidate_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .min_len    (min_len),
        .max_len    (max_len),
        .cs_len     (cs_len),
        .cs_ord     (cs_ord),
        .cs_char    (cs_char),
        .cand_valid (cand_valid),
        .cand_ready (cand_ready),
        .cand_data  (cand_data),
        .cand_len   (cand_len),
        .busy       (busy),
        .done       (done)
    );

    assign cs_char = cs_mem[cs_ord];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_cs(input string s);
        for (int i = 0; i < 64; i++) cs_mem[i] = '0;
        for (int i = 0; i < s.len(); i++) cs_mem[i] = CHAR_W'(s[i]);
    endtask

    function automatic int pw(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    // Candidate n of length L: digits of n in base radix, position 0 least significant.
    function automatic logic [63:0] exp_cand(input int L, input int n, input int radix);
        logic [63:0] r = '0;
        int v = n;
        if (radix == 0) return '0;
        for (int p = 0; p < L; p++) begin
            r[p*CHAR_W +: CHAR_W] = cs_mem[v % radix];
            v = v / radix;
        end
        return r;
    endfunction

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cs_ord"}, cs_ord, 0);
        chk({tag, "_cand_valid"}, cand_valid, 0);
        chk({tag, "_cand_data"}, cand_data, 0);
        chk({tag, "_cand_len"}, cand_len, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Caller is at a negedge; start is raised immediately so back-to-back calls
    // present start in the IDLE cycle right after done.
    task automatic do_run(input string s, input int mn, input int mx, input int n_cs,
                          input bit bp, input bit poke, input int exp_cnt);
        int  edges, L, n, cnt, last_hs;
        bit  first, hs_seen, prev_stall, got_done;
        logic [MAX_LEN*CHAR_W-1:0] prev_data;
        load_cs(s);
        cs_len     = IDX_W'(n_cs);
        min_len    = LEN_W'(mn);
        max_len    = LEN_W'(mx);
        cand_ready = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1; L = mn; n = 0; cnt = 0; last_hs = 0;
        first = 1'b1; hs_seen = 1'b0; prev_stall = 1'b0; got_done = 1'b0;
        prev_data = '0;
        while (edges < 5000 && !got_done) begin
            cand_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && edges == 3) begin
                start  = 1'b1;
                cs_len = IDX_W'(1);
            end else begin
                start = 1'b0;
            end
            if (prev_stall) begin
                chk("stall_valid", cand_valid, 1);
                chk("stall_data", cand_data, prev_data);
            end
            if (done) begin
                chk("done_latency", edges, last_hs + 1);
                chk("busy_in_done", busy, 1);
                chk("cand_count", cnt, exp_cnt);
                @(negedge clk);
                chk("done_one_cycle", done, 0);
                chk("busy_after_done", busy, 0);
                got_done = 1'b1;
            end else begin
                if (cand_valid && first) begin
                    chk("first_valid_latency", edges, mn + 1);
                    first = 1'b0;
                end
                if (cand_valid && cand_ready) begin
                    $display("cand %0d len=%0d data=%0h", cnt, cand_len, cand_data);
                    chk("cand_data", cand_data, exp_cand(L, n, n_cs));
                    chk("cand_len", cand_len, L);
                    if (!bp && hs_seen) chk("hs_gap", edges + 1 - last_hs, L + 2);
                    last_hs = edges + 1;
                    hs_seen = 1'b1;
                    cnt++;
                    n++;
                    if (n == pw(n_cs, L)) begin
                        L++;
                        n = 0;
                    end
                end
                prev_stall = cand_valid && !cand_ready;
                prev_data  = cand_data;
                edges++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!got_done) chk("run_timeout", 1, 0);
    endtask

    // Walk "ab" at length 2 until the third candidate is being fetched (pos 1)
    // or offered, then reset there.
    task automatic reset_mid_run(input bit in_offer);
        int  hs = 0;
        bit  hit = 1'b0;
        load_cs("ab");
        cs_len = IDX_W'(2); min_len = LEN_W'(2); max_len = LEN_W'(2);
        cand_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (in_offer) cand_ready = (hs < 2);
            if (hs == 2 && (in_offer ? cand_valid : (cs_ord == IDX_W'(1)))) begin
                hit = 1'b1;
            end else begin
                if (cand_valid && cand_ready) hs++;
                @(negedge clk);
            end
        end
        chk(in_offer ? "reached_offer" : "reached_fetch", hit, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_outs(in_offer ? "rst_offer" : "rst_fetch");
        cand_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cand_ready = 1'b0;
        min_len = '0; max_len = '0; cs_len = '0;
        load_cs("ab");
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outs("idle");

        do_run("ab", 1, 2, 2, 1'b0, 1'b1, 6);
        do_run("xyz", 3, 3, 3, 1'b1, 1'b0, 27);
        do_run("ab", 1, 2, 0, 1'b0, 1'b0, 0);
        do_run("ab", 3, 2, 2, 1'b0, 1'b0, 0);
        do_run("ab", 1, 9, 2, 1'b0, 1'b0, 0);
        do_run("q", 1, 8, 1, 1'b0, 1'b0, 8);

        reset_mid_run(1'b0);
        do_run("ab", 2, 2, 2, 1'b0, 1'b0, 4);
        reset_mid_run(1'b1);
        do_run("ab", 2, 2, 2, 1'b0, 1'b0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/candidate_sequencer.md
# candidate_sequencer

Brute-force candidate generator for the cracker front end. Walks every string over the loaded character set, shortest length first, from `min_len` up to `max_len`. For each candidate it reads the charset one position per cycle through the charset's single combinational lookup port (`ord` → `char`). It then offers the packed candidate to the hash core over a valid/ready handshake. It sits between the charset store and the hash core and owns the charset read port while busy.

## Interface
- `MAX_LEN`, default 8: maximum candidate length in characters.
- `CHAR_W`, default 7: character width; matches the charset entry width.
- `IDX_W`, default 6: charset index width, up to 64 entries.
- `LEN_W`, default 4: width of the length fields; must hold `MAX_LEN`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: begin enumeration; sampled only in IDLE.
- `min_len` in `LEN_W`: shortest length to generate.
- `max_len` in `LEN_W`: longest length to generate.
- `cs_len` in `IDX_W`: charset entry count; sampled into a register on `start`.
- `cs_ord` out `IDX_W`: charset read index.
- `cs_char` in `CHAR_W`: charset read data, combinational from `cs_ord`.
- `cand_valid` out 1: candidate available.
- `cand_ready` in 1: hash core accepts the candidate.
- `cand_data` out `MAX_LEN*CHAR_W`: candidate; position p occupies bits [p*CHAR_W +: CHAR_W].
- `cand_len` out `LEN_W`: candidate length.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when enumeration ends.

## Operation
- State registers: `idx[0..MAX_LEN-1]` (`IDX_W` each), `cur_len`, `pos`, `len_q` (registered `cs_len`).
- States: IDLE, FETCH, OFFER, STEP, DONE.
- **IDLE**
  - On `start`, the configuration is valid when `cs_len`≠0 and 1≤`min_len`≤`max_len`≤`MAX_LEN`.
  - Valid configuration: clear all `idx`, set `cur_len`=`min_len` and `pos`=0, clear `cand_data`, go to FETCH.
  - Invalid configuration: go to DONE; no candidates are produced.
- **FETCH**
  - `cs_ord`=`idx[pos]`; on each edge, `cs_char` is written into byte `pos` of `cand_data`.
  - When `pos`=`cur_len`−1, go to OFFER; otherwise increment `pos`.
- **OFFER**
  - `cand_valid`=1 and `cand_len`=`cur_len`.
  - On `cand_valid`&&`cand_ready`, go to STEP.
- **STEP** (odometer increment, position 0 least significant)
  - `idx[0]` increments. Any digit that reaches `len_q` wraps to 0 and carries into the next position.
  - If the carry leaves position `cur_len`−1 and `cur_len`=`max_len`: go to DONE.
  - If the carry leaves position `cur_len`−1 and `cur_len`<`max_len`: increment `cur_len`, clear all `idx`, and clear `cand_data`.
  - In every case except DONE: `pos`=0, go to FETCH.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- Bytes at positions ≥`cur_len` are always zero.
- `cs_ord`=0 in every state other than FETCH.
- Total candidates = Σ `len_q`^L for L=`min_len`..`max_len`.
- Charset writes while `busy` is high are outside the contract; `len_q` isolates the walk from changes to `cs_len`.

## Timing
- Reset values: `cs_ord`=0, `cand_valid`=0, `cand_data`=0, `cand_len`=0, `busy`=0, `done`=0; state=IDLE.
- `reset` takes effect from any state, including OFFER with `cand_valid` high. Outputs are at reset values on the next edge.
- Once raised, `cand_valid` and `cand_data` stay stable until the handshake edge. `cand_valid` falls on the edge that completes the handshake.
- First `cand_valid` rises `min_len`+1 edges after the edge that samples `start`.
- With `cand_ready` held high, there are `cur_len`+2 cycles from one handshake to the next.
- `done` rises 1 edge after the final handshake. On an invalid configuration it rises 1 edge after `start`.
- `start` is ignored while `busy` is high.

## Structure
- Package `cracker_pkg` holds the `MAX_LEN`, `CHAR_W`, `IDX_W` and `LEN_W` defaults and the state enum `cand_state_t`.
- Sub-module `index_odometer` holds the `idx` array.
  - Controls: clear, step, `len_q`, `cur_len`.
  - Outputs: `carry_out`, plus a read mux selected by `pos`.

## Test plan
- Charset "ab", `min_len`=1, `max_len`=2, `cand_ready`=1:
  - Candidates are a, b, aa, ba, ab, bb, with `cand_len` 1,1,2,2,2,2.
  - `done` pulses once; 6 handshakes total.
- Charset "xyz", `min_len`=`max_len`=3, random `cand_ready` backpressure:
  - 27 candidates in odometer order.
  - `cand_data` is stable while `cand_valid` is high and `cand_ready` is low.
- Invalid start cases, each must give `done` 1 edge after `start`, zero candidates, and `busy` high for exactly 1 cycle:
  - `cs_len`=0;
  - `min_len`=3 with `max_len`=2;
  - `max_len`=9.
- Single character "q", `min_len`=1, `max_len`=`MAX_LEN`:
  - 8 candidates "q" through "qqqqqqqq".
  - Upper bytes are zero for every candidate shorter than 8.
- Reset asserted during FETCH, and separately during OFFER:
  - Next cycle shows all outputs at reset values.
  - A following `start` restarts from index 0.
- `start` pulsed while busy is ignored. Back-to-back runs: `start` one cycle after `done` works normally.
